multicycle_control_fsm: RTL and testbench

- Control sequencer for the multicycle variant of the MIPS core.
- Steps a shared ALU, one unified instruction/data memory and the PC/IR/A/B/ALUOut registers through FETCH/DECODE/execute phases: R-type, lw, sw, beq, j.
- Waits on a memory-ready handshake and flags unsupported opcodes.
- Sits beside the datapath, driven by IR[31:26] and the ALU zero flag.

---
 rtl/cpu_ctrl_pkg.sv | 59 +++++
 rtl/multicycle_ctrl_decode.sv | 74 +++++++
 rtl/multicycle_control_fsm.sv | 103 ++++++++++
 tb/tb_multicycle_control_fsm.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control sequencer: states, opcodes,
// datapath selector codes and the packed control vector driven to the datapath.
package cpu_ctrl_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;

  // RESET must stay at zero so the debug state output is also zero in reset
  typedef enum logic [STATE_W-1:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_HALT   = 4'd11
  } state_e;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational control-vector decode: state, memory handshake and ALU zero
// flag to datapath strobes and selectors.
module multicycle_ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  state_e state_i,
  input  logic   mem_ready_i,
  input  logic   zero_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        // PC and IR advance together only once the fetch has completed
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_en     = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMM_SH2;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.iord       = 1'b1;
        ctrl_o.instr_done = mem_ready_i;
      end
      S_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a  = 1'b1;
        ctrl_o.alu_src_b  = SRCB_B;
        ctrl_o.alu_op     = ALUOP_SUB;
        ctrl_o.pc_source  = PCSRC_ALUOUT;
        ctrl_o.pc_en      = zero_i;
        ctrl_o.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_source  = PCSRC_JUMP;
        ctrl_o.pc_en      = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control sequencer: state register, next-state logic and the
// sticky illegal-opcode flag; control outputs come from multicycle_ctrl_decode.
module multicycle_control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] OPcode,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            PCEn,
  output logic            IorD,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic            RegDst,
  output logic            MemtoReg,
  output logic            RegWrite,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ALUOp,
  output logic [1:0]      PCSource,
  output logic            instr_done,
  output logic            illegal,
  output logic [STATE_W-1:0] state_dbg
);

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   nop_done;
  ctrl_t  ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RESET;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = S_RESET;
    illegal_d = illegal_q;
    nop_done  = 1'b0;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (OPcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal_d = 1'b1;
            if (ILLEGAL_TRAP) begin
              state_d = S_HALT;
            end else begin
              state_d  = S_FETCH;
              nop_done = 1'b1;
            end
          end
        endcase
      end
      S_MEMADR: state_d = (OPcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      // unused encodings recover through RESET
      default:  state_d = S_RESET;
    endcase
  end

  multicycle_ctrl_decode u_decode (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .zero_i      (zero),
    .ctrl_o      (ctrl)
  );

  assign PCEn       = ctrl.pc_en;
  assign IorD       = ctrl.iord;
  assign MemRead    = ctrl.mem_read;
  assign MemWrite   = ctrl.mem_write;
  assign IRWrite    = ctrl.ir_write;
  assign RegDst     = ctrl.reg_dst;
  assign MemtoReg   = ctrl.mem_to_reg;
  assign RegWrite   = ctrl.reg_write;
  assign ALUSrcA    = ctrl.alu_src_a;
  assign ALUSrcB    = ctrl.alu_src_b;
  assign ALUOp      = ctrl.alu_op;
  assign PCSource   = ctrl.pc_source;
  assign instr_done = ctrl.instr_done | nop_done;
  assign illegal    = illegal_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: both ILLEGAL_TRAP settings run in
// lockstep; per-cycle expected output vectors go through a scoreboard queue.
module tb_multicycle_control_fsm;
  import cpu_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] OPcode;
  logic       zero;
  logic       mem_ready;

  logic PCEn1, IorD1, MemRead1, MemWrite1, IRWrite1, RegDst1, MemtoReg1, RegWrite1, ALUSrcA1;
  logic [1:0] ALUSrcB1, ALUOp1, PCSource1;
  logic instr_done1, illegal1;
  logic [3:0] state_dbg1;

  logic PCEn0, IorD0, MemRead0, MemWrite0, IRWrite0, RegDst0, MemtoReg0, RegWrite0, ALUSrcA0;
  logic [1:0] ALUSrcB0, ALUOp0, PCSource0;
  logic instr_done0, illegal0;
  logic [3:0] state_dbg0;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.ILLEGAL_TRAP(1'b1)) dut_trap (
    .clk(clk), .rst_n(rst_n), .OPcode(OPcode), .zero(zero), .mem_ready(mem_ready),
    .PCEn(PCEn1), .IorD(IorD1), .MemRead(MemRead1), .MemWrite(MemWrite1),
    .IRWrite(IRWrite1), .RegDst(RegDst1), .MemtoReg(MemtoReg1), .RegWrite(RegWrite1),
    .ALUSrcA(ALUSrcA1), .ALUSrcB(ALUSrcB1), .ALUOp(ALUOp1), .PCSource(PCSource1),
    .instr_done(instr_done1), .illegal(illegal1), .state_dbg(state_dbg1)
  );

  multicycle_control_fsm #(.ILLEGAL_TRAP(1'b0)) dut_nop (
    .clk(clk), .rst_n(rst_n), .OPcode(OPcode), .zero(zero), .mem_ready(mem_ready),
    .PCEn(PCEn0), .IorD(IorD0), .MemRead(MemRead0), .MemWrite(MemWrite0),
    .IRWrite(IRWrite0), .RegDst(RegDst0), .MemtoReg(MemtoReg0), .RegWrite(RegWrite0),
    .ALUSrcA(ALUSrcA0), .ALUSrcB(ALUSrcB0), .ALUOp(ALUOp0), .PCSource(PCSource0),
    .instr_done(instr_done0), .illegal(illegal0), .state_dbg(state_dbg0)
  );

  logic [20:0] obs1, obs0;
  assign obs1 = {PCEn1, IorD1, MemRead1, MemWrite1, IRWrite1, RegDst1, MemtoReg1, RegWrite1,
                 ALUSrcA1, ALUSrcB1, ALUOp1, PCSource1, instr_done1, illegal1, state_dbg1};
  assign obs0 = {PCEn0, IorD0, MemRead0, MemWrite0, IRWrite0, RegDst0, MemtoReg0, RegWrite0,
                 ALUSrcA0, ALUSrcB0, ALUOp0, PCSource0, instr_done0, illegal0, state_dbg0};

  typedef struct {
    logic [20:0] v1;
    logic [20:0] v0;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   pcen_cnt = 0;
  int   irw_cnt = 0;

  // Expected output vector for a state, straight from the per-state output table
  function automatic logic [20:0] expv(input state_e st, input logic mr, input logic z,
                                       input logic ill, input logic xdone);
    logic pcen, iord, mrd, mwr, irw, rdst, m2r, rw, srca, done;
    logic [1:0] srcb, aop, pcs;
    {pcen, iord, mrd, mwr, irw, rdst, m2r, rw, srca, done} = '0;
    srcb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (st)
      S_FETCH:  begin mrd = 1'b1; srcb = 2'b01; irw = mr; pcen = mr; end
      S_DECODE: begin srcb = 2'b11; done = xdone; end
      S_MEMADR: begin srca = 1'b1; srcb = 2'b10; end
      S_MEMRD:  begin mrd = 1'b1; iord = 1'b1; end
      S_MEMWB:  begin rw = 1'b1; m2r = 1'b1; done = 1'b1; end
      S_MEMWR:  begin mwr = 1'b1; iord = 1'b1; done = mr; end
      S_EXEC:   begin srca = 1'b1; aop = 2'b10; end
      S_ALUWB:  begin rw = 1'b1; rdst = 1'b1; done = 1'b1; end
      S_BRANCH: begin srca = 1'b1; aop = 2'b01; pcs = 2'b01; pcen = z; done = 1'b1; end
      S_JUMP:   begin pcs = 2'b10; pcen = 1'b1; done = 1'b1; end
      default:  ;
    endcase
    return {pcen, iord, mrd, mwr, irw, rdst, m2r, rw, srca, srcb, aop, pcs, done, ill, 4'(st)};
  endfunction

  // One clock cycle: drive inputs, queue the expectation, compare at the falling edge
  task automatic cyc(input logic [5:0] op, input logic mr, input logic z,
                     input logic [20:0] e1, input logic [20:0] e0, input string tag);
    exp_t e;
    exp_t got;
    OPcode = op; mem_ready = mr; zero = z;
    e.v1 = e1; e.v0 = e0; e.tag = tag;
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    checks++;
    assert (obs1 === got.v1) else begin
      errors++;
      $error("FAIL %s trap1 observed=%h expected=%h", got.tag, obs1, got.v1);
    end
    checks++;
    assert (obs0 === got.v0) else begin
      errors++;
      $error("FAIL %s trap0 observed=%h expected=%h", got.tag, obs0, got.v0);
    end
    pcen_cnt += int'(PCEn1);
    irw_cnt  += int'(IRWrite1);
    @(posedge clk);
    #1;
  endtask

  task automatic st(input logic [5:0] op, input logic mr, input logic z,
                    input state_e s, input string tag);
    cyc(op, mr, z, expv(s, mr, z, 1'b0, 1'b0), expv(s, mr, z, 1'b0, 1'b0), tag);
  endtask

  initial begin
    int pc0, ir0;
    rst_n = 1'b0; OPcode = 6'd0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    #1;
    st(6'h00, 1'b1, 1'b0, S_RESET, "reset_hold_a");
    st(6'h00, 1'b1, 1'b0, S_RESET, "reset_hold_b");
    rst_n = 1'b1;
    st(6'h00, 1'b1, 1'b0, S_RESET, "reset_release");

    // R-type; opcode disturbed during EXEC must be ignored
    st(6'h00, 1'b1, 1'b0, S_FETCH,  "r_fetch");
    st(OP_RTYPE, 1'b1, 1'b0, S_DECODE, "r_decode");
    st(6'h3f, 1'b1, 1'b0, S_EXEC,   "r_exec");
    st(6'h3f, 1'b1, 1'b0, S_ALUWB,  "r_aluwb");

    // lw with 2 fetch waits and 3 read waits: 10 cycles
    pc0 = pcen_cnt; ir0 = irw_cnt;
    st(6'h00, 1'b0, 1'b0, S_FETCH,  "lw_fetch_wait1");
    st(6'h00, 1'b0, 1'b0, S_FETCH,  "lw_fetch_wait2");
    st(6'h00, 1'b1, 1'b0, S_FETCH,  "lw_fetch");
    st(OP_LW, 1'b1, 1'b0, S_DECODE, "lw_decode");
    st(OP_LW, 1'b1, 1'b0, S_MEMADR, "lw_memadr");
    st(OP_LW, 1'b0, 1'b0, S_MEMRD,  "lw_memrd_wait1");
    st(OP_LW, 1'b0, 1'b0, S_MEMRD,  "lw_memrd_wait2");
    st(OP_LW, 1'b0, 1'b0, S_MEMRD,  "lw_memrd_wait3");
    st(OP_LW, 1'b1, 1'b0, S_MEMRD,  "lw_memrd");
    st(OP_LW, 1'b1, 1'b0, S_MEMWB,  "lw_memwb");
    checks++;
    assert (pcen_cnt - pc0 == 1) else begin
      errors++;
      $error("FAIL lw_pcen_pulses observed=%0d expected=1", pcen_cnt - pc0);
    end
    checks++;
    assert (irw_cnt - ir0 == 1) else begin
      errors++;
      $error("FAIL lw_irwrite_pulses observed=%0d expected=1", irw_cnt - ir0);
    end

    // sw with one write wait
    st(6'h00, 1'b1, 1'b0, S_FETCH,  "sw_fetch");
    st(OP_SW, 1'b1, 1'b0, S_DECODE, "sw_decode");
    st(OP_SW, 1'b1, 1'b0, S_MEMADR, "sw_memadr");
    st(OP_SW, 1'b0, 1'b0, S_MEMWR,  "sw_memwr_wait");
    st(OP_SW, 1'b1, 1'b0, S_MEMWR,  "sw_memwr");

    // beq taken then not taken
    st(6'h00,  1'b1, 1'b0, S_FETCH,  "beq_t_fetch");
    st(OP_BEQ, 1'b1, 1'b1, S_DECODE, "beq_t_decode");
    st(OP_BEQ, 1'b1, 1'b1, S_BRANCH, "beq_taken");
    st(6'h00,  1'b1, 1'b0, S_FETCH,  "beq_n_fetch");
    st(OP_BEQ, 1'b1, 1'b0, S_DECODE, "beq_n_decode");
    st(OP_BEQ, 1'b1, 1'b0, S_BRANCH, "beq_not_taken");

    // jump, then the 4th cycle is a new FETCH
    st(6'h00, 1'b1, 1'b0, S_FETCH,  "j_fetch");
    st(OP_J,  1'b1, 1'b0, S_DECODE, "j_decode");
    st(OP_J,  1'b1, 1'b0, S_JUMP,   "j_jump");
    st(6'h00, 1'b1, 1'b0, S_FETCH,  "j_back_fetch");

    // reset asserted while a store is waiting in MEMWR
    st(OP_SW, 1'b1, 1'b0, S_DECODE, "rst_sw_decode");
    st(OP_SW, 1'b1, 1'b0, S_MEMADR, "rst_sw_memadr");
    st(OP_SW, 1'b0, 1'b0, S_MEMWR,  "rst_sw_memwr");
    rst_n = 1'b0;
    st(OP_SW, 1'b0, 1'b0, S_RESET,  "rst_mid_memwr");
    rst_n = 1'b1;
    st(6'h00, 1'b1, 1'b0, S_RESET,  "rst_release2");
    st(6'h00, 1'b1, 1'b0, S_FETCH,  "post_rst_fetch");

    // illegal opcode: trap instance halts, NOP instance retires and refetches
    cyc(6'h3f, 1'b1, 1'b0, expv(S_DECODE, 1'b1, 1'b0, 1'b0, 1'b0),
        expv(S_DECODE, 1'b1, 1'b0, 1'b0, 1'b1), "illegal_decode");
    for (int i = 0; i < 20; i++) begin
      cyc(6'h3f, 1'b0, 1'b0, expv(S_HALT, 1'b0, 1'b0, 1'b1, 1'b0),
          expv(S_FETCH, 1'b0, 1'b0, 1'b1, 1'b0), "illegal_hold");
    end
    rst_n = 1'b0;
    st(6'h00, 1'b1, 1'b0, S_RESET, "illegal_cleared_by_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
